kernel_conv3x3: RTL

Pipelined 3x3 convolution stage that consumes the kernel stream produced by the row-buffer/kernel-window block directly upstream. Each pixel-type beat is convolved with a programmable signed 3x3 coefficient matrix, then rounded, shifted and clamped back to pixel width. All non-pixel beats (frame/row markers, header words) pass through unchanged. Output timing is identical for every beat, so downstream stages see the same stream format they would see without this block.

---
 rtl/kernel_conv3x3_pkg.sv | 31 +++
 rtl/conv3x3_row_mac.sv | 36 +++
 rtl/kernel_conv3x3.sv | 113 +++++++++++
 3 files changed

// File: rtl/kernel_conv3x3_pkg.sv
// kernel_conv3x3_pkg: beat type codes shared with the stream blocks, plus derived
// datapath widths for the 3x3 convolution stage.
package kernel_conv3x3_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'h5;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h8;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'h8;

    // Growth over the product width: three-term row sum, nine-term total.
    localparam int ROW_GROW   = 2;
    localparam int TOTAL_GROW = 4;

    function automatic int prod_width(int pixel_width, int coef_width);
        return pixel_width + coef_width + 1;
    endfunction

    function automatic int row_width(int pixel_width, int coef_width);
        return prod_width(pixel_width, coef_width) + ROW_GROW;
    endfunction

    function automatic int total_width(int pixel_width, int coef_width);
        return prod_width(pixel_width, coef_width) + TOTAL_GROW;
    endfunction

endpackage

// File: rtl/conv3x3_row_mac.sv
// conv3x3_row_mac: one window row times three signed coefficients; products are
// registered in stage 1 and the row sum in stage 2.
module conv3x3_row_mac
    import kernel_conv3x3_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int COEF_WIDTH  = 8,
    localparam int PW = prod_width(PIXEL_WIDTH, COEF_WIDTH),
    localparam int RW = row_width(PIXEL_WIDTH, COEF_WIDTH)
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic [3*PIXEL_WIDTH-1:0] pix,
    input  logic [3*COEF_WIDTH-1:0]  coef,
    output logic signed [RW-1:0]     row_sum
);

    logic signed [PW-1:0] prod_d [3];
    logic signed [PW-1:0] prod   [3];

    // Pixels are unsigned, so a zero MSB is prepended before the signed multiply.
    for (genvar c = 0; c < 3; c++) begin : g_mul
        assign prod_d[c] = PW'($signed({1'b0, pix[c*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                         * PW'($signed(coef[c*COEF_WIDTH +: COEF_WIDTH]));
    end

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            prod    <= '{default: '0};
            row_sum <= '0;
        end else begin
            prod    <= prod_d;
            row_sum <= RW'(prod[0]) + RW'(prod[1]) + RW'(prod[2]);
        end

endmodule

// File: rtl/kernel_conv3x3.sv
// kernel_conv3x3: 3-cycle 3x3 convolution of pixel beats with round/shift/clamp; other
// beats pass through. KERNEL_CONV_COEF_SHADOW_EN latches coef/shift on each frame start.
module kernel_conv3x3
    import kernel_conv3x3_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int COEF_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     dvi,
    input  logic [DTYPE_WIDTH-1:0]   dtypei,
    input  logic [DATA_WIDTH-1:0]    meta_datai,
    input  logic [9*PIXEL_WIDTH-1:0] kernel_datai,
    input  logic                     enable,
    input  logic [9*COEF_WIDTH-1:0]  coef,
    input  logic [SHIFT_WIDTH-1:0]   shift,
    output logic                     dvo,
    output logic [DTYPE_WIDTH-1:0]   dtypeo,
    output logic [DATA_WIDTH-1:0]    datao
);

    localparam int RW = row_width(PIXEL_WIDTH, COEF_WIDTH);
    localparam int TW = total_width(PIXEL_WIDTH, COEF_WIDTH);

    logic [9*COEF_WIDTH-1:0] coef_use;
    logic [SHIFT_WIDTH-1:0]  shift_use;

`ifdef KERNEL_CONV_COEF_SHADOW_EN
    logic [9*COEF_WIDTH-1:0] coef_sh;
    logic [SHIFT_WIDTH-1:0]  shift_sh;

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            coef_sh  <= '0;
            shift_sh <= '0;
        end else if (dvi && dtypei == DTYPE_FRAME_START) begin
            coef_sh  <= coef;
            shift_sh <= shift;
        end

    assign coef_use  = coef_sh;
    assign shift_use = shift_sh;
`else
    assign coef_use  = coef;
    assign shift_use = shift;
`endif

    logic signed [RW-1:0] row_sum [3];

    for (genvar r = 0; r < 3; r++) begin : g_row
        conv3x3_row_mac #(
            .PIXEL_WIDTH(PIXEL_WIDTH),
            .COEF_WIDTH (COEF_WIDTH)
        ) u_row (
            .clk    (clk),
            .resetb (resetb),
            .pix    (kernel_datai[r*3*PIXEL_WIDTH +: 3*PIXEL_WIDTH]),
            .coef   (coef_use[r*3*COEF_WIDTH +: 3*COEF_WIDTH]),
            .row_sum(row_sum[r])
        );
    end

    logic                   dv1, dv2, pix1, pix2;
    logic [DTYPE_WIDTH-1:0] dt1, dt2;
    logic [DATA_WIDTH-1:0]  meta1, meta2;
    logic [SHIFT_WIDTH-1:0] sh1, sh2;

    // Sideband travels alongside the MAC pipeline so every beat sees the same latency.
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            {dv1, dv2, pix1, pix2} <= '0;
            {dt1, dt2}             <= '0;
            {meta1, meta2}         <= '0;
            {sh1, sh2}             <= '0;
        end else begin
            dv1   <= dvi;
            dt1   <= dtypei;
            meta1 <= meta_datai;
            pix1  <= dvi && enable && |(dtypei & DTYPE_PIXEL_MASK);
            sh1   <= shift_use;
            dv2   <= dv1;
            dt2   <= dt1;
            meta2 <= meta1;
            pix2  <= pix1;
            sh2   <= sh1;
        end

    logic signed [TW:0]     total, half, scaled;
    logic [PIXEL_WIDTH-1:0] clamped;

    // One spare bit above the total keeps the rounding add from wrapping.
    always_comb begin
        total   = (TW+1)'(row_sum[0]) + (TW+1)'(row_sum[1]) + (TW+1)'(row_sum[2]);
        half    = (sh2 == '0) ? '0 : (TW+1)'(1) << (sh2 - SHIFT_WIDTH'(1));
        scaled  = (total + half) >>> sh2;
        clamped = scaled[TW] ? '0 : (|scaled[TW-1:PIXEL_WIDTH] ? '1 : scaled[PIXEL_WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            dvo    <= 1'b0;
            dtypeo <= '0;
            datao  <= '0;
        end else begin
            dvo    <= dv2;
            dtypeo <= dt2;
            datao  <= pix2 ? DATA_WIDTH'(clamped) : meta2;
        end

endmodule
